// File: rtl/evm_pkg.sv
// Shared types and constants for the ballot controller slice.
package evm_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_HOLD    = 3'd2,
    S_CAST    = 3'd3,
    S_LOCKOUT = 3'd4,
    S_CLOSED  = 3'd5
  } state_e;

  localparam int IDX_P1   = 0;
  localparam int IDX_P2   = 1;
  localparam int IDX_P3   = 2;
  localparam int IDX_P4   = 3;
  localparam int IDX_P5   = 4;
  localparam int IDX_NOTA = 5;
  localparam int N_BTN    = 6;

  localparam int CNT_W_DEFAULT = 10;

endpackage

// File: rtl/evm_ballot_controller_if.sv
// Officer/button/counter-facing signal bundle of the ballot controller.
interface evm_ballot_controller_if
  import evm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic             BALLOT_EN;
  logic             CLOSE_POLL;
  logic             P1;
  logic             P2;
  logic             P3;
  logic             P4;
  logic             P5;
  logic             NOTA;
  logic [N_BTN-1:0] CAST;
  logic             READY;
  logic             ARMED;
  logic             BEEP;
  logic             TIMEOUT_PULSE;
  logic             POLL_CLOSED;
  logic [CNT_W-1:0] BALLOTS_CAST;

  modport master (
    output BALLOT_EN, CLOSE_POLL, P1, P2, P3, P4, P5, NOTA,
    input  CAST, READY, ARMED, BEEP, TIMEOUT_PULSE, POLL_CLOSED, BALLOTS_CAST
  );

  modport slave (
    input  BALLOT_EN, CLOSE_POLL, P1, P2, P3, P4, P5, NOTA,
    output CAST, READY, ARMED, BEEP, TIMEOUT_PULSE, POLL_CLOSED, BALLOTS_CAST
  );

endinterface

// File: rtl/evm_down_timer.sv
// Loadable down-counter that saturates at zero; used for ballot timeout and beep length.
module evm_down_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  assign o_zero = (r_count == '0);

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples the pre-edge value of the others.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && !o_zero) begin
      r_count <= r_count - W'(1);
    end
  end

endmodule

// File: rtl/evm_ballot_controller.sv
// Presiding-officer ballot controller: arms one ballot, debounces a single
// candidate press, pulses the matching counter input, then beeps and locks out.
module evm_ballot_controller
  import evm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BEEP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic                    CLK,
  input  logic                    CLEAR_N,
  evm_ballot_controller_if.slave  bus
);

  localparam int TO_W   = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int BEEP_W = (BEEP_CYCLES < 1) ? 1 : $clog2(BEEP_CYCLES + 1);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

  // The armed window spans TIMEOUT_CYCLES cycles, the arming cycle included.
  localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BEEP_W-1:0] BEEP_LOAD = BEEP_W'(BEEP_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  state_e           r_state, w_state_next;
  logic [N_BTN-1:0] r_sel, w_sel_next;
  logic [DB_W-1:0]  r_match, w_match_next;
  logic             r_close_pend, w_close_pend_next;

  logic [N_BTN-1:0] r_cast;
  logic             r_ready, r_armed, r_beep, r_timeout, r_closed;
  logic [CNT_W-1:0] r_ballots, w_ballots_next;

  logic [N_BTN-1:0] w_btn;
  logic             w_one_hot, w_saturated, w_timeout;
  logic             w_to_load, w_to_en, w_to_zero;
  logic             w_beep_load, w_beep_en, w_beep_zero;

  assign w_btn[IDX_P1]   = bus.P1;
  assign w_btn[IDX_P2]   = bus.P2;
  assign w_btn[IDX_P3]   = bus.P3;
  assign w_btn[IDX_P4]   = bus.P4;
  assign w_btn[IDX_P5]   = bus.P5;
  assign w_btn[IDX_NOTA] = bus.NOTA;

  assign w_one_hot   = (w_btn != '0) && ((w_btn & (w_btn - N_BTN'(1))) == '0);
  assign w_saturated = (r_ballots == '1);
  assign w_ballots_next = (r_state == S_CAST && !w_saturated) ? r_ballots + CNT_W'(1) : r_ballots;

  evm_down_timer #(.W(TO_W)) u_timeout_timer (
    .i_clk      (CLK),
    .i_rst_n    (CLEAR_N),
    .i_load     (w_to_load),
    .i_load_val (TO_LOAD),
    .i_en       (w_to_en),
    .o_zero     (w_to_zero)
  );

  evm_down_timer #(.W(BEEP_W)) u_beep_timer (
    .i_clk      (CLK),
    .i_rst_n    (CLEAR_N),
    .i_load     (w_beep_load),
    .i_load_val (BEEP_LOAD),
    .i_en       (w_beep_en),
    .o_zero     (w_beep_zero)
  );

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    w_state_next      = r_state;
    w_sel_next        = r_sel;
    w_match_next      = r_match;
    w_close_pend_next = r_close_pend;
    w_to_load         = 1'b0;
    w_to_en           = 1'b0;
    w_beep_load       = 1'b0;
    w_beep_en         = 1'b0;
    w_timeout         = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.CLOSE_POLL) begin
          w_state_next = S_CLOSED;
        end else if (bus.BALLOT_EN && !w_saturated) begin
          w_state_next = S_ARMED;
          w_to_load    = 1'b1;
          w_match_next = '0;
        end
      end
      S_ARMED: begin
        w_to_en = 1'b1;
        if (bus.CLOSE_POLL) begin
          w_state_next = S_CLOSED;
        end else if (w_to_zero) begin
          w_state_next = S_IDLE;
          w_timeout    = 1'b1;
        end else if (w_one_hot) begin
          w_state_next = (DEBOUNCE_CYCLES <= 1) ? S_CAST : S_HOLD;
          w_sel_next   = w_btn;
          w_match_next = DB_W'(1);
        end
      end
      S_HOLD: begin
        w_to_en = 1'b1;
        if (bus.CLOSE_POLL) begin
          w_state_next = S_CLOSED;
        end else if (w_btn == r_sel && r_match == DB_LAST) begin
          // A completed debounce beats a timer expiring on the same edge.
          w_state_next = S_CAST;
          w_match_next = r_match + DB_W'(1);
        end else if (w_to_zero) begin
          w_state_next = S_IDLE;
          w_timeout    = 1'b1;
        end else if (w_btn == r_sel) begin
          w_match_next = r_match + DB_W'(1);
        end else begin
          w_state_next = S_ARMED;
          w_match_next = '0;
        end
      end
      S_CAST: begin
        w_state_next = S_LOCKOUT;
        w_beep_load  = 1'b1;
        if (bus.CLOSE_POLL) w_close_pend_next = 1'b1;
      end
      S_LOCKOUT: begin
        w_beep_en = 1'b1;
        if (bus.CLOSE_POLL) w_close_pend_next = 1'b1;
        if (w_beep_zero && w_btn == '0) begin
          w_state_next = (r_close_pend || bus.CLOSE_POLL) ? S_CLOSED : S_IDLE;
        end
      end
      S_CLOSED: begin
        w_state_next = S_CLOSED;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!CLEAR_N) begin
      r_state      <= S_IDLE;
      r_sel        <= '0;
      r_match      <= '0;
      r_close_pend <= 1'b0;
      r_cast       <= '0;
      r_ready      <= 1'b1;
      r_armed      <= 1'b0;
      r_beep       <= 1'b0;
      r_timeout    <= 1'b0;
      r_closed     <= 1'b0;
      r_ballots    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_sel        <= w_sel_next;
      r_match      <= w_match_next;
      r_close_pend <= w_close_pend_next;
      r_cast       <= (r_state == S_CAST) ? r_sel : '0;
      r_ballots    <= w_ballots_next;
      r_ready      <= (w_state_next == S_IDLE) && (w_ballots_next != '1);
      r_armed      <= (w_state_next == S_ARMED) || (w_state_next == S_HOLD);
      r_beep       <= (r_state == S_LOCKOUT) && !w_beep_zero;
      r_timeout    <= w_timeout;
      r_closed     <= (w_state_next == S_CLOSED);
    end
  end

  assign bus.CAST          = r_cast;
  assign bus.READY         = r_ready;
  assign bus.ARMED         = r_armed;
  assign bus.BEEP          = r_beep;
  assign bus.TIMEOUT_PULSE = r_timeout;
  assign bus.POLL_CLOSED   = r_closed;
  assign bus.BALLOTS_CAST  = r_ballots;

endmodule

// File: tb/tb_evm_ballot_controller.sv
// Directed bench: main DUT (timeout 20, 10-bit count) plus a 3-bit-count DUT for saturation.
module tb_evm_ballot_controller;

  logic CLK = 1'b0;
  logic CLEAR_N = 1'b0;
  int   checks = 0;
  int   errors = 0;

  evm_ballot_controller_if #(.CNT_W(10)) bus_a ();
  evm_ballot_controller_if #(.CNT_W(3))  bus_b ();

  evm_ballot_controller #(
    .DEBOUNCE_CYCLES(4), .BEEP_CYCLES(8), .TIMEOUT_CYCLES(20), .CNT_W(10)
  ) u_dut_a (
    .CLK(CLK), .CLEAR_N(CLEAR_N), .bus(bus_a)
  );

  evm_ballot_controller #(
    .DEBOUNCE_CYCLES(4), .BEEP_CYCLES(8), .TIMEOUT_CYCLES(20), .CNT_W(3)
  ) u_dut_b (
    .CLK(CLK), .CLEAR_N(CLEAR_N), .bus(bus_b)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic btn_a(input logic [5:0] v);
    {bus_a.NOTA, bus_a.P5, bus_a.P4, bus_a.P3, bus_a.P2, bus_a.P1} = v;
  endtask

  task automatic btn_b(input logic [5:0] v);
    {bus_b.NOTA, bus_b.P5, bus_b.P4, bus_b.P3, bus_b.P2, bus_b.P1} = v;
  endtask

  task automatic arm_a();
    bus_a.BALLOT_EN = 1'b1;
    step(1);
    bus_a.BALLOT_EN = 1'b0;
  endtask

  task automatic wait_ready_a(input string tag, input int limit);
    int n = 0;
    while (bus_a.READY !== 1'b1 && n < limit) begin
      step(1);
      n++;
    end
    check(tag, {15'd0, bus_a.READY}, 16'd1);
  endtask

  // One full ballot on the saturation DUT: press held 4 samples, then lockout drains.
  task automatic vote_b(input logic [5:0] v);
    bus_b.BALLOT_EN = 1'b1;
    step(1);
    bus_b.BALLOT_EN = 1'b0;
    btn_b(v);
    step(4);
    btn_b(6'b0);
    step(14);
  endtask

  initial begin
    int   beeps;
    logic seen;

    bus_a.BALLOT_EN = 1'b0; bus_a.CLOSE_POLL = 1'b0; btn_a(6'b0);
    bus_b.BALLOT_EN = 1'b0; bus_b.CLOSE_POLL = 1'b0; btn_b(6'b0);

    // Reset values
    step(3);
    check("rst READY", {15'd0, bus_a.READY}, 16'd1);
    check("rst ARMED", {15'd0, bus_a.ARMED}, 16'd0);
    check("rst CAST", {10'd0, bus_a.CAST}, 16'd0);
    check("rst BEEP", {15'd0, bus_a.BEEP}, 16'd0);
    check("rst TIMEOUT_PULSE", {15'd0, bus_a.TIMEOUT_PULSE}, 16'd0);
    check("rst POLL_CLOSED", {15'd0, bus_a.POLL_CLOSED}, 16'd0);
    check("rst BALLOTS_CAST", {6'd0, bus_a.BALLOTS_CAST}, 16'd0);
    CLEAR_N = 1'b1;
    step(1);

    // P3 held: cast exactly 4 edges after first sample, then 30 cycles of holding
    arm_a();
    check("t1 ARMED", {15'd0, bus_a.ARMED}, 16'd1);
    check("t1 READY low while armed", {15'd0, bus_a.READY}, 16'd0);
    btn_a(6'b000100);
    for (int i = 1; i <= 4; i++) begin
      step(1);
      check("t1 no early CAST", {10'd0, bus_a.CAST}, 16'd0);
    end
    step(1);
    check("t1 CAST P3", {10'd0, bus_a.CAST}, 16'h0004);
    check("t1 BALLOTS 1", {6'd0, bus_a.BALLOTS_CAST}, 16'd1);
    check("t1 ARMED drops", {15'd0, bus_a.ARMED}, 16'd0);
    beeps = 0;
    seen  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      beeps += int'(bus_a.BEEP);
      if (bus_a.CAST !== 6'b0) seen = 1'b1;
    end
    check("t2 BEEP cycles", 16'(beeps), 16'd8);
    check("t2 no second CAST", {15'd0, seen}, 16'd0);
    check("t2 READY held in lockout", {15'd0, bus_a.READY}, 16'd0);
    check("t2 BALLOTS still 1", {6'd0, bus_a.BALLOTS_CAST}, 16'd1);
    btn_a(6'b0);
    step(1);
    check("t2 READY after release", {15'd0, bus_a.READY}, 16'd1);

    // P1+P2 together, then P1 released with P2 still held
    arm_a();
    btn_a(6'b000011);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (bus_a.CAST !== 6'b0 || bus_a.ARMED !== 1'b1) seen = 1'b1;
    end
    check("t3 dual press ignored", {15'd0, seen}, 16'd0);
    btn_a(6'b000010);
    step(4);
    check("t3 no early CAST", {10'd0, bus_a.CAST}, 16'd0);
    step(1);
    check("t3 CAST P2", {10'd0, bus_a.CAST}, 16'h0002);
    check("t3 BALLOTS 2", {6'd0, bus_a.BALLOTS_CAST}, 16'd2);
    btn_a(6'b0);
    wait_ready_a("t3 READY returns", 40);

    // Two-cycle P4 glitch rejected, then NOTA held exactly 4 samples
    arm_a();
    btn_a(6'b001000);
    step(2);
    btn_a(6'b0);
    step(1);
    check("t4 ARMED after glitch", {15'd0, bus_a.ARMED}, 16'd1);
    check("t4 no CAST on glitch", {10'd0, bus_a.CAST}, 16'd0);
    btn_a(6'b100000);
    step(4);
    btn_a(6'b0);
    check("t4 no early CAST", {10'd0, bus_a.CAST}, 16'd0);
    step(1);
    check("t4 CAST NOTA", {10'd0, bus_a.CAST}, 16'h0020);
    check("t4 BALLOTS 3", {6'd0, bus_a.BALLOTS_CAST}, 16'd3);
    wait_ready_a("t4 READY returns", 40);

    // Timeout: pulse exactly 20 edges after the arming edge
    arm_a();
    seen = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      step(1);
      if (bus_a.TIMEOUT_PULSE !== 1'b0) seen = 1'b1;
    end
    check("t5 no early TIMEOUT", {15'd0, seen}, 16'd0);
    step(1);
    check("t5 TIMEOUT_PULSE", {15'd0, bus_a.TIMEOUT_PULSE}, 16'd1);
    check("t5 READY", {15'd0, bus_a.READY}, 16'd1);
    check("t5 ARMED cleared", {15'd0, bus_a.ARMED}, 16'd0);
    step(1);
    check("t5 pulse one cycle", {15'd0, bus_a.TIMEOUT_PULSE}, 16'd0);
    check("t5 BALLOTS unchanged", {6'd0, bus_a.BALLOTS_CAST}, 16'd3);

    // CLOSE_POLL during lockout: cast completes, then closed for good
    arm_a();
    btn_a(6'b010000);
    step(5);
    check("t6 CAST P5", {10'd0, bus_a.CAST}, 16'h0010);
    bus_a.CLOSE_POLL = 1'b1;
    step(1);
    bus_a.CLOSE_POLL = 1'b0;
    btn_a(6'b0);
    check("t6 not closed during lockout", {15'd0, bus_a.POLL_CLOSED}, 16'd0);
    begin
      int n = 0;
      while (bus_a.POLL_CLOSED !== 1'b1 && n < 40) begin
        step(1);
        n++;
      end
    end
    check("t6 POLL_CLOSED", {15'd0, bus_a.POLL_CLOSED}, 16'd1);
    check("t6 READY low", {15'd0, bus_a.READY}, 16'd0);
    check("t6 BALLOTS 4", {6'd0, bus_a.BALLOTS_CAST}, 16'd4);
    bus_a.BALLOT_EN = 1'b1;
    btn_a(6'b000001);
    step(8);
    check("t6 BALLOT_EN ignored", {15'd0, bus_a.ARMED}, 16'd0);
    check("t6 no vote when closed", {6'd0, bus_a.BALLOTS_CAST}, 16'd4);
    bus_a.BALLOT_EN = 1'b0;
    btn_a(6'b0);

    // Saturation with a 3-bit count
    for (int v = 1; v <= 7; v++) begin
      vote_b(6'b000001 << ((v - 1) % 6));
      if (v == 6) check("t7 READY before max", {15'd0, bus_b.READY}, 16'd1);
    end
    check("t7 BALLOTS 7", {13'd0, bus_b.BALLOTS_CAST}, 16'd7);
    check("t7 READY at max", {15'd0, bus_b.READY}, 16'd0);
    bus_b.BALLOT_EN = 1'b1;
    step(3);
    bus_b.BALLOT_EN = 1'b0;
    check("t7 no arm at max", {15'd0, bus_b.ARMED}, 16'd0);
    check("t7 no wrap", {13'd0, bus_b.BALLOTS_CAST}, 16'd7);

    // Reset clears closed poll; reset mid-hold abandons the ballot
    CLEAR_N = 1'b0;
    step(2);
    CLEAR_N = 1'b1;
    check("t8 POLL_CLOSED cleared", {15'd0, bus_a.POLL_CLOSED}, 16'd0);
    check("t8 BALLOTS cleared", {6'd0, bus_a.BALLOTS_CAST}, 16'd0);
    check("t8 B READY restored", {15'd0, bus_b.READY}, 16'd1);
    arm_a();
    btn_a(6'b000010);
    step(3);
    CLEAR_N = 1'b0;
    step(1);
    btn_a(6'b0);
    CLEAR_N = 1'b1;
    check("t8 ARMED after reset", {15'd0, bus_a.ARMED}, 16'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (bus_a.CAST !== 6'b0) seen = 1'b1;
    end
    check("t8 no CAST after reset", {15'd0, seen}, 16'd0);
    check("t8 BALLOTS zero", {6'd0, bus_a.BALLOTS_CAST}, 16'd0);

    // CLOSE_POLL while armed cancels without a timeout pulse
    arm_a();
    bus_a.CLOSE_POLL = 1'b1;
    step(1);
    bus_a.CLOSE_POLL = 1'b0;
    check("t9 POLL_CLOSED from ARMED", {15'd0, bus_a.POLL_CLOSED}, 16'd1);
    check("t9 ARMED cancelled", {15'd0, bus_a.ARMED}, 16'd0);
    check("t9 no TIMEOUT_PULSE", {15'd0, bus_a.TIMEOUT_PULSE}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/evm_ballot_controller.md
Name: evm_ballot_controller

Overview:
- Presiding-officer ballot controller placed in front of electronic_voting_machine.
- Arms one ballot per BALLOT_EN, debounces the six candidate buttons and accepts exactly one stable one-hot press.
- Issues a single-cycle cast pulse to the matching counter input (P1..P5, NOTA), then beeps and locks out until all buttons are released.
- Handles ballot timeout, poll closing and ballot-count saturation.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical one-hot samples required before a vote is accepted.
- BEEP_CYCLES, 8: BEEP duration after a cast.
- TIMEOUT_CYCLES, 1000: cycles an armed ballot may wait before it is cancelled.
- CNT_W, 10: width of BALLOTS_CAST; matches the counter width.

Ports:
- CLK  in  1  clock, rising edge
- CLEAR_N  in  1  reset, synchronous, active-low
- BALLOT_EN  in  1  officer issues one ballot; level, sampled in IDLE only
- CLOSE_POLL  in  1  end of poll; level, sampled every cycle
- P1, P2, P3, P4, P5, NOTA  in  1 each  raw candidate buttons, synchronous to CLK
- CAST  out  6  one-hot cast pulse, bit order {NOTA,P5,P4,P3,P2,P1}; drives counter inputs
- READY  out  1  a ballot may be issued
- ARMED  out  1  ballot active, awaiting a press
- BEEP  out  1  confirmation buzzer
- TIMEOUT_PULSE  out  1  one-cycle flag: ballot cancelled by timeout
- POLL_CLOSED  out  1  poll closed; cleared only by reset
- BALLOTS_CAST  out  CNT_W  total accepted votes

Behaviour:
- One clock domain. Reset is synchronous, active-low. All state and outputs are registered.
- Reset values: state IDLE; CAST=0; ARMED=0; BEEP=0; TIMEOUT_PULSE=0; POLL_CLOSED=0; BALLOTS_CAST=0; READY=1.
- FSM states: IDLE, ARMED, HOLD, CAST, LOCKOUT, CLOSED.
- IDLE:
  - READY = !saturated, where saturated means BALLOTS_CAST == 2^CNT_W-1.
  - BALLOT_EN & READY -> ARMED; load the timeout timer with TIMEOUT_CYCLES.
  - BALLOT_EN in any other state, or when saturated, is ignored.
- ARMED: sample the 6-bit button vector each cycle.
  - Exactly one bit set -> HOLD; latch it as SEL; match count = 1.
  - Zero bits or more than one bit set -> stay in ARMED.
- HOLD:
  - Vector == SEL -> increment match count; reaching DEBOUNCE_CYCLES -> CAST.
  - Any mismatch (release, extra button, different button) -> ARMED; match count cleared.
- Timer:
  - Decrements in ARMED and HOLD.
  - At 0 -> IDLE with TIMEOUT_PULSE high for 1 cycle.
  - If debounce completion and timer expiry occur in the same cycle, the cast wins.
- CAST: lasts exactly 1 cycle.
  - CAST = SEL; BALLOTS_CAST increments.
  - The pulse is visible DEBOUNCE_CYCLES edges after the edge that first sampled the one-hot vector in ARMED.
  - Always -> LOCKOUT.
- LOCKOUT:
  - BEEP high for exactly BEEP_CYCLES cycles.
  - Exits to IDLE only when the beep has finished AND all buttons read 0. Holding a button therefore never casts twice.
- ARMED output = state is ARMED or HOLD.
- CLOSE_POLL:
  - In IDLE, ARMED or HOLD -> CLOSED next cycle; any armed ballot is cancelled with no cast and no TIMEOUT_PULSE.
  - In CAST or LOCKOUT -> set a sticky pending flag; the cast completes normally; CLOSED is entered instead of IDLE.
- CLOSED: POLL_CLOSED=1, READY=0; all inputs ignored until reset.
- Saturation: BALLOTS_CAST never wraps; at maximum, READY stays 0, so downstream counters cannot overflow.
- Reset mid-operation: abandons any ballot, no CAST is emitted, all values return to reset values.

Decomposition:
- Package evm_pkg holds:
  - state enum encoding;
  - button index constants IDX_P1..IDX_NOTA (0..5);
  - CNT_W default.
- Sub-module evm_down_timer: loadable down-counter with load, enable and zero flag. It is instantiated twice, once for the timeout and once for the beep.
- One-hot check and debounce counter stay inline in the FSM.

Test Plan:
- Reset, pulse BALLOT_EN, hold P3 for 6 cycles -> CAST=6'b000100 for exactly 1 cycle, 4 edges after first sample; BALLOTS_CAST=1; BEEP high 8 cycles; READY=1 after P3 is released.
- Keep P3 held for 30 cycles after the cast, with no new ballot -> no second CAST; stays in LOCKOUT until release; BALLOTS_CAST stays 1.
- Arm; press P1+P2 together for 10 cycles, then release P1 (P2 still held) -> no cast during the dual press; then a single cast of 6'b000010.
- Arm; P4 glitch lasting 2 cycles -> no CAST, ARMED stays 1; then NOTA held 4 cycles -> CAST=6'b100000.
- TIMEOUT_CYCLES=20: arm, no press -> TIMEOUT_PULSE exactly 20 cycles after arming; READY=1; BALLOTS_CAST unchanged.
- Assert CLOSE_POLL during LOCKOUT -> cast completes, then POLL_CLOSED=1, READY=0, later BALLOT_EN ignored.
- With CNT_W=3: 7 ballots -> BALLOTS_CAST=7 and READY stays 0.
